// File: rtl/id_stage.sv
// RV64 decode stage: IF/ID capture, control decode, immediate generation,
// 32x64 register file with writeback bypass, and the ID/EX pipeline register.
module id_stage #(
    parameter int          XLEN      = 64,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] PC_D,
    input  logic [31:0]     instruction_D,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            FlushE,
    input  logic            RegWrite_W,
    input  logic [4:0]      Rd_W,
    input  logic [XLEN-1:0] Result_W,
    output logic [XLEN-1:0] PC_E,
    output logic [XLEN-1:0] RD1_E,
    output logic [XLEN-1:0] RD2_E,
    output logic [XLEN-1:0] ImmExt_E,
    output logic [4:0]      Rs1_E,
    output logic [4:0]      Rs2_E,
    output logic [4:0]      Rd_E,
    output logic [2:0]      Funct3_E,
    output logic            RegWrite_E,
    output logic            MemWrite_E,
    output logic            MemRead_E,
    output logic            Branch_E,
    output logic            Jump_E,
    output logic [1:0]      ResultSrc_E,
    output logic [1:0]      ALUSrcA_E,
    output logic            ALUSrcB_E,
    output logic [3:0]      ALUControl_E,
    output logic            Valid_E,
    output logic            Illegal_E
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    // Illegal lives in the control group so a bubble clears it with the rest.
    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       branch;
        logic       jump;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic       alu_src_b;
        logic [3:0] alu_ctrl;
        logic       illegal;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        ctrl_t           ctrl;
        logic            valid;
    } idex_t;

    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
    endfunction

    // IF/ID
    logic [XLEN-1:0] if_pc;
    logic [31:0]     if_inst;
    logic            if_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            if_pc    <= '0;
            if_inst  <= NOP_INSTR;
            if_valid <= 1'b0;
        end else if (FlushD) begin
            if_inst  <= NOP_INSTR;
            if_valid <= 1'b0;
        end else if (!StallD) begin
            if_pc    <= PC_D;
            if_inst  <= instruction_D;
            if_valid <= 1'b1;
        end
    end

    // Register file
    logic [XLEN-1:0] rf [32];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (RegWrite_W && Rd_W != 5'd0) begin
            rf[Rd_W] <= Result_W;
        end
    end

    logic [4:0]      rs1, rs2;
    logic [XLEN-1:0] rd1, rd2;
    logic            wb_live;

    assign rs1     = if_inst[19:15];
    assign rs2     = if_inst[24:20];
    assign wb_live = RegWrite_W && (Rd_W != 5'd0);
    assign rd1     = (rs1 == 5'd0) ? '0 : (wb_live && Rd_W == rs1) ? Result_W : rf[rs1];
    assign rd2     = (rs2 == 5'd0) ? '0 : (wb_live && Rd_W == rs2) ? Result_W : rf[rs2];

    // Immediates
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = {{(XLEN-12){if_inst[31]}}, if_inst[31:20]};
    assign imm_s = {{(XLEN-12){if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
    assign imm_b = {{(XLEN-13){if_inst[31]}}, if_inst[31], if_inst[7], if_inst[30:25], if_inst[11:8], 1'b0};
    assign imm_u = {{(XLEN-32){if_inst[31]}}, if_inst[31:12], 12'b0};
    assign imm_j = {{(XLEN-21){if_inst[31]}}, if_inst[31], if_inst[19:12], if_inst[20], if_inst[30:21], 1'b0};

    // Decode
    ctrl_t           ctrl;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    idex_t           idex_d, idex_q;

    always_comb begin
        ctrl = '0;
        imm  = '0;
        rd   = if_inst[11:7];
        case (if_inst[6:0])
            OP_R: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_ctrl  = alu_op(if_inst[14:12], if_inst[30]);
            end
            OP_IMM: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src_b = 1'b1;
                ctrl.alu_ctrl  = alu_op(if_inst[14:12], if_inst[14:12] == 3'b101 && if_inst[30]);
                imm            = imm_i;
            end
            OP_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.result_src = 2'b01;
                ctrl.alu_src_b  = 1'b1;
                imm             = imm_i;
            end
            OP_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src_b = 1'b1;
                imm            = imm_s;
                rd             = 5'd0;
            end
            OP_BRANCH: begin
                ctrl.branch   = 1'b1;
                ctrl.alu_ctrl = ALU_SUB;
                imm           = imm_b;
                rd            = 5'd0;
            end
            OP_JAL: begin
                ctrl.jump       = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = 2'b10;
                ctrl.alu_src_a  = 2'b01;
                ctrl.alu_src_b  = 1'b1;
                imm             = imm_j;
            end
            OP_JALR: begin
                ctrl.jump       = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = 2'b10;
                ctrl.alu_src_b  = 1'b1;
                imm             = imm_i;
            end
            OP_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src_a = 2'b10;
                ctrl.alu_src_b = 1'b1;
                imm            = imm_u;
            end
            OP_AUIPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src_a = 2'b01;
                ctrl.alu_src_b = 1'b1;
                imm            = imm_u;
            end
            default: ctrl.illegal = 1'b1;
        endcase
        // The flush NOP decodes as a legal addi; the valid bit is what marks it dead.
        if (!if_valid) ctrl = '0;

        idex_d        = '0;
        idex_d.pc     = if_pc;
        idex_d.rd1    = rd1;
        idex_d.rd2    = rd2;
        idex_d.imm    = imm;
        idex_d.rs1    = rs1;
        idex_d.rs2    = rs2;
        idex_d.rd     = rd;
        idex_d.funct3 = if_inst[14:12];
        idex_d.ctrl   = ctrl;
        idex_d.valid  = if_valid;
    end

    // ID/EX: no hold path; a load-use stall arrives as StallD with FlushE.
    always_ff @(posedge clk) begin
        if (!reset || FlushE) idex_q <= '0;
        else                  idex_q <= idex_d;
    end

    assign PC_E         = idex_q.pc;
    assign RD1_E        = idex_q.rd1;
    assign RD2_E        = idex_q.rd2;
    assign ImmExt_E     = idex_q.imm;
    assign Rs1_E        = idex_q.rs1;
    assign Rs2_E        = idex_q.rs2;
    assign Rd_E         = idex_q.rd;
    assign Funct3_E     = idex_q.funct3;
    assign RegWrite_E   = idex_q.ctrl.reg_write;
    assign MemWrite_E   = idex_q.ctrl.mem_write;
    assign MemRead_E    = idex_q.ctrl.mem_read;
    assign Branch_E     = idex_q.ctrl.branch;
    assign Jump_E       = idex_q.ctrl.jump;
    assign ResultSrc_E  = idex_q.ctrl.result_src;
    assign ALUSrcA_E    = idex_q.ctrl.alu_src_a;
    assign ALUSrcB_E    = idex_q.ctrl.alu_src_b;
    assign ALUControl_E = idex_q.ctrl.alu_ctrl;
    assign Valid_E      = idex_q.valid;
    assign Illegal_E    = idex_q.ctrl.illegal;
endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed cases plus randomized traffic,
// checked against an instruction-level reference model.
module tb_id_stage;
    localparam logic [31:0] NOP = 32'h00000013;
    localparam int K_RST  = 0;
    localparam int K_BUB  = 1;
    localparam int K_FULL = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] PC_D;
    logic [31:0] instruction_D;
    logic        StallD, FlushD, FlushE, RegWrite_W;
    logic [4:0]  Rd_W;
    logic [63:0] Result_W;
    logic [63:0] PC_E, RD1_E, RD2_E, ImmExt_E;
    logic [4:0]  Rs1_E, Rs2_E, Rd_E;
    logic [2:0]  Funct3_E;
    logic        RegWrite_E, MemWrite_E, MemRead_E, Branch_E, Jump_E;
    logic [1:0]  ResultSrc_E, ALUSrcA_E;
    logic        ALUSrcB_E;
    logic [3:0]  ALUControl_E;
    logic        Valid_E, Illegal_E;

    id_stage dut (
        .clk(clk), .reset(reset), .PC_D(PC_D), .instruction_D(instruction_D),
        .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .RegWrite_W(RegWrite_W), .Rd_W(Rd_W), .Result_W(Result_W),
        .PC_E(PC_E), .RD1_E(RD1_E), .RD2_E(RD2_E), .ImmExt_E(ImmExt_E),
        .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E), .Funct3_E(Funct3_E),
        .RegWrite_E(RegWrite_E), .MemWrite_E(MemWrite_E), .MemRead_E(MemRead_E),
        .Branch_E(Branch_E), .Jump_E(Jump_E), .ResultSrc_E(ResultSrc_E),
        .ALUSrcA_E(ALUSrcA_E), .ALUSrcB_E(ALUSrcB_E), .ALUControl_E(ALUControl_E),
        .Valid_E(Valid_E), .Illegal_E(Illegal_E)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    logic [13:0] ctrl_act;
    assign ctrl_act = {RegWrite_E, MemWrite_E, MemRead_E, Branch_E, Jump_E,
                       ResultSrc_E, ALUSrcA_E, ALUSrcB_E, ALUControl_E};

    typedef struct {
        int          edge_no;
        int          kind;
        logic [63:0] pc, rd1, rd2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [13:0] ctrl;
        logic        illegal;
        bit          use1, use2, use_imm, use_rd;
    } exp_t;

    exp_t exp_q[$];

    // Reference state: architectural registers and the instruction waiting in decode.
    logic [63:0] m_regs [32];
    logic [63:0] m_pc;
    logic [31:0] m_inst;
    bit          m_valid;

    int          alu_tab [8] = '{0, 5, 8, 9, 4, 6, 3, 2};
    logic [6:0]  legal_ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [63:0] sext(input longint unsigned v, input int bits);
        if (((v >> (bits - 1)) & 1) != 0) return v - (64'd1 << bits);
        return v;
    endfunction

    function automatic exp_t blank();
        exp_t e;
        e.edge_no = 0; e.kind = K_RST;
        e.pc = 0; e.rd1 = 0; e.rd2 = 0; e.imm = 0;
        e.rs1 = 0; e.rs2 = 0; e.rd = 0; e.f3 = 0; e.ctrl = 0; e.illegal = 0;
        e.use1 = 0; e.use2 = 0; e.use_imm = 0; e.use_rd = 0;
        return e;
    endfunction

    function automatic exp_t decode(input logic [31:0] in, input logic [63:0] pc,
                                    input logic [63:0] r1, input logic [63:0] r2);
        exp_t e;
        bit rw = 0, mw = 0, mr = 0, br = 0, jp = 0, sb = 0;
        logic [1:0] rsrc = 0, sa = 0;
        int alu = 0;
        logic [2:0] f3;
        f3 = in[14:12];
        e = blank();
        e.kind = K_FULL; e.pc = pc; e.f3 = f3;
        e.rs1 = in[19:15]; e.rs2 = in[24:20]; e.rd = in[11:7];
        e.rd1 = r1; e.rd2 = r2; e.use_rd = 1; e.use_imm = 1;
        case (in[6:0])
            7'h33: begin rw = 1; alu = alu_tab[f3] + int'(in[30] && (f3 == 0 || f3 == 5));
                         e.use1 = 1; e.use2 = 1; e.use_imm = 0; end
            7'h13: begin rw = 1; sb = 1; alu = alu_tab[f3] + int'(in[30] && f3 == 5);
                         e.imm = sext(in[31:20], 12); e.use1 = 1; end
            7'h03: begin rw = 1; mr = 1; rsrc = 1; sb = 1; e.imm = sext(in[31:20], 12); e.use1 = 1; end
            7'h23: begin mw = 1; sb = 1; e.imm = sext({in[31:25], in[11:7]}, 12);
                         e.rd = 0; e.use1 = 1; e.use2 = 1; end
            7'h63: begin br = 1; alu = 1; e.imm = sext({in[31], in[7], in[30:25], in[11:8], 1'b0}, 13);
                         e.rd = 0; e.use1 = 1; e.use2 = 1; end
            7'h6F: begin jp = 1; rw = 1; rsrc = 2; sa = 1; sb = 1;
                         e.imm = sext({in[31], in[19:12], in[20], in[30:21], 1'b0}, 21); end
            7'h67: begin jp = 1; rw = 1; rsrc = 2; sb = 1; e.imm = sext(in[31:20], 12); e.use1 = 1; end
            7'h37: begin rw = 1; sa = 2; sb = 1; e.imm = sext({in[31:12], 12'b0}, 32); end
            7'h17: begin rw = 1; sa = 1; sb = 1; e.imm = sext({in[31:12], 12'b0}, 32); end
            default: begin e.illegal = 1; e.use_rd = 0; e.use_imm = 0; end
        endcase
        e.ctrl = {rw, mw, mr, br, jp, rsrc, sa, sb, 4'(alu)};
        return e;
    endfunction

    function automatic logic [63:0] m_read(input logic [4:0] r);
        if (r == 0) return 0;
        if (RegWrite_W && Rd_W == r) return Result_W;
        return m_regs[r];
    endfunction

    // Predict the ID/EX contents after the coming edge, then advance the model.
    task automatic tick();
        exp_t e;
        if (!reset)                  e = blank();
        else if (FlushE || !m_valid) begin e = blank(); e.kind = K_BUB; end
        else e = decode(m_inst, m_pc, m_read(m_inst[19:15]), m_read(m_inst[24:20]));
        e.edge_no = edge_cnt + 1;
        exp_q.push_back(e);
        if (!reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 0;
            m_pc = 0; m_inst = NOP; m_valid = 0;
        end else begin
            if (RegWrite_W && Rd_W != 0) m_regs[Rd_W] = Result_W;
            if (FlushD) begin m_inst = NOP; m_valid = 0; end
            else if (!StallD) begin m_pc = PC_D; m_inst = instruction_D; m_valid = 1; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input exp_t e);
        chk("valid", Valid_E, e.kind == K_FULL);
        chk("ctrl", ctrl_act, e.ctrl);
        chk("illegal", Illegal_E, e.illegal);
        if (e.kind == K_RST) begin
            chk("rst_pc", PC_E, 0);
            chk("rst_rd", {RD1_E ^ RD2_E, 64'(ImmExt_E != 0)}, 0);
            chk("rst_idx", {Rs1_E, Rs2_E, Rd_E, Funct3_E}, 0);
        end else if (e.kind == K_FULL) begin
            chk("pc", PC_E, e.pc);
            if (!e.illegal) chk("funct3", Funct3_E, e.f3);
            if (e.use_rd)  chk("rd", Rd_E, e.rd);
            if (e.use_imm) chk("imm", ImmExt_E, e.imm);
            if (e.use1) begin chk("rs1", Rs1_E, e.rs1); chk("rd1", RD1_E, e.rd1); end
            if (e.use2) begin chk("rs2", Rs2_E, e.rs2); chk("rd2", RD2_E, e.rd2); end
        end
    endtask

    // Monitor: compare every edge's ID/EX contents against its queued prediction.
    initial begin
        exp_t m;
        forever begin
            @(negedge clk);
            while (exp_q.size() != 0 && exp_q[0].edge_no <= edge_cnt) begin
                m = exp_q.pop_front();
                check_out(m);
            end
        end
    end

    task automatic idle();
        reset = 1; StallD = 0; FlushD = 0; FlushE = 0;
        RegWrite_W = 0; Rd_W = 0; Result_W = 0; instruction_D = NOP;
    endtask

    function automatic bit is_legal(input logic [6:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] in;
        logic [6:0]  op;
        in = $urandom;
        in[19:15] = 5'($urandom_range(0, 7));
        in[24:20] = 5'($urandom_range(0, 7));
        if ($urandom_range(0, 9) == 0) begin
            do op = 7'($urandom_range(0, 127)); while (is_legal(op));
        end else begin
            op = legal_ops[$urandom_range(0, 8)];
        end
        in[6:0] = op;
        return in;
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 0;
        m_pc = 0; m_inst = NOP; m_valid = 0;
        idle();
        PC_D = 0;

        // Reset with garbage on the inputs, then read x5
        reset = 0; instruction_D = 32'h00A00093; PC_D = 64'h40; RegWrite_W = 1; Rd_W = 5; Result_W = 64'h55;
        tick(); tick();
        chk("d_rst_valid", Valid_E, 0);
        chk("d_rst_pc", PC_E, 0);
        chk("d_rst_ctrl", ctrl_act, 0);
        idle(); instruction_D = 32'h00528333; PC_D = 64'h80;
        tick(); instruction_D = NOP; tick();
        chk("d_rst_x5", RD1_E, 0);

        // addi x1,x0,-5
        instruction_D = 32'hFFB00093; PC_D = 64'h100; tick();
        instruction_D = NOP; PC_D = 64'h104; tick();
        chk("d_addi_pc", PC_E, 64'h100);
        chk("d_addi_imm", ImmExt_E, 64'hFFFF_FFFF_FFFF_FFFB);
        chk("d_addi_ctl", {RegWrite_E, ALUSrcB_E, ALUControl_E}, {1'b1, 1'b1, 4'd0});
        chk("d_addi_rd", Rd_E, 1);

        // Bypass on add x4,x3,x3, then a write to x0 against add x4,x0,x0
        instruction_D = 32'h00318233; tick();
        instruction_D = 32'h00000233; RegWrite_W = 1; Rd_W = 3; Result_W = 64'hDEAD; tick();
        chk("d_byp_rd1", RD1_E, 64'hDEAD);
        chk("d_byp_rd2", RD2_E, 64'hDEAD);
        instruction_D = NOP; Rd_W = 0; Result_W = 64'hBEEF; tick();
        chk("d_x0_rd1", RD1_E, 0);
        RegWrite_W = 0;

        // Load-use stall, then StallD+FlushD
        instruction_D = 32'hFFB00093; PC_D = 64'h200; tick();
        instruction_D = 32'h00000233; PC_D = 64'h204; StallD = 1; FlushE = 1; tick();
        chk("d_stall_valid", Valid_E, 0);
        chk("d_stall_rw", RegWrite_E, 0);
        StallD = 0; FlushE = 0; tick();
        chk("d_held_pc", PC_E, 64'h200);
        chk("d_held_valid", Valid_E, 1);
        StallD = 1; FlushD = 1; tick();
        StallD = 0; FlushD = 0; instruction_D = NOP; tick();
        chk("d_flushd_valid", Valid_E, 0);

        // beq -8, jal +0x800
        instruction_D = 32'hFE000CE3; PC_D = 64'h300; tick();
        instruction_D = NOP; tick();
        chk("d_beq_imm", ImmExt_E, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("d_beq_br", Branch_E, 1);
        chk("d_beq_rd", Rd_E, 0);
        instruction_D = 32'h001000EF; tick();
        instruction_D = NOP; tick();
        chk("d_jal_imm", ImmExt_E, 64'h800);
        chk("d_jal_rsrc", ResultSrc_E, 2'b10);

        // Illegal opcode
        instruction_D = 32'h0000007F; tick();
        instruction_D = NOP; tick();
        chk("d_ill", {Illegal_E, Valid_E}, 2'b11);
        chk("d_ill_ctrl", ctrl_act, 0);

        // Reset while a valid instruction sits in IF/ID
        instruction_D = 32'hFFB00093; tick();
        reset = 0; tick();
        chk("d_mrst_valid", Valid_E, 0);
        reset = 1; tick();
        chk("d_mrst_after", Valid_E, 0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            reset         = ($urandom_range(0, 99) != 0);
            StallD        = ($urandom_range(0, 7) == 0);
            FlushD        = ($urandom_range(0, 11) == 0);
            FlushE        = ($urandom_range(0, 11) == 0);
            RegWrite_W    = 1'($urandom_range(0, 1));
            Rd_W          = 5'($urandom_range(0, 7));
            Result_W      = {$urandom, $urandom};
            PC_D          = {$urandom, $urandom};
            instruction_D = rand_inst();
            tick();
        end
        idle();
        @(negedge clk);
        #1;
        chk("drain", 64'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage of the 64-bit RISC-V pipeline, directly downstream of instruction fetch.
- Captures the fetched PC and instruction into the IF/ID pipeline register.
- Decodes control, generates the sign-extended immediate, and reads the 32x64 register file (with writeback bypass).
- Registers all results into the ID/EX pipeline register for the execute stage. Stall and flush inputs come from the hazard unit.

Parameters:
- XLEN, 64, datapath / PC width.
- NOP_INSTR, 32'h00000013, instruction injected into IF/ID on flush (addi x0,x0,0).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset).
- PC_D  input  XLEN  PC of the fetched instruction.
- instruction_D  input  32  fetched instruction.
- StallD  input  1  hold IF/ID contents.
- FlushD  input  1  replace IF/ID contents with a bubble.
- FlushE  input  1  load a bubble into ID/EX.
- RegWrite_W  input  1  writeback enable.
- Rd_W  input  5  writeback destination register.
- Result_W  input  XLEN  writeback data.
- PC_E  output  XLEN  registered PC.
- RD1_E, RD2_E  output  XLEN  registered rs1/rs2 read data.
- ImmExt_E  output  XLEN  registered sign-extended immediate.
- Rs1_E, Rs2_E, Rd_E  output  5  registered register indices (for forwarding).
- Funct3_E  output  3  registered funct3 (branch condition, load/store size).
- RegWrite_E, MemWrite_E, MemRead_E, Branch_E, Jump_E  output  1  registered control.
- ResultSrc_E  output  2  00 ALU, 01 memory, 10 PC+4.
- ALUSrcA_E  output  2  00 rs1, 01 PC, 10 zero.
- ALUSrcB_E  output  1  0 rs2, 1 immediate.
- ALUControl_E  output  4  ALU operation code (encoding under Behaviour).
- Valid_E  output  1  ID/EX holds a real instruction.
- Illegal_E  output  1  unsupported opcode decoded.

Behaviour:
- Reset (reset==0 at posedge):
  - IF/ID is loaded with PC=0, instruction=NOP_INSTR, valid=0.
  - All 32 register file entries are cleared to 0.
  - Every ID/EX output goes to 0.
  - Reset has priority over every other input.
- IF/ID register, per posedge, in priority order: reset > FlushD (load NOP_INSTR, valid=0) > StallD (hold) > load PC_D/instruction_D with valid=1.
- ID/EX register, per posedge, in priority order: reset > FlushE (all control, Valid_E and Illegal_E = 0; data fields don't-care, driven 0) > load decoded values.
  - ID/EX has no hold. A load-use stall is expressed by the hazard unit as StallD=1 together with FlushE=1.
- Latency: an instruction presented at edge N reaches the ID/EX outputs after edge N+1 (2-cycle fetch-to-execute visibility).
- Register file:
  - Write on posedge when RegWrite_W=1 and Rd_W!=0. Writes to x0 are discarded; reading x0 always returns 0.
  - Reads are combinational from the IF/ID instruction.
  - Bypass: if RegWrite_W=1, Rd_W!=0 and Rd_W equals rs1 (or rs2), the read returns Result_W in the same cycle.
- Immediates (all sign-extended from bit 31 to XLEN):
  - I: inst[31:20].
  - S: {inst[31:25],inst[11:7]}.
  - B: {inst[31],inst[7],inst[30:25],inst[11:8],0}.
  - U: {inst[31:12],12'b0}, sign-extended.
  - J: {inst[31],inst[19:12],inst[20],inst[30:21],0}.
- ALUControl encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
- Decode by opcode:
  - R 0110011: RegWrite, rs1/rs2. funct7[5] selects SUB/SRA.
  - I-ALU 0010011: RegWrite, rs1/imm. funct7[5] selects SRAI only for funct3=101.
  - Load 0000011: RegWrite, MemRead, ResultSrc=01, ADD rs1+imm.
  - Store 0100011: MemWrite, ADD rs1+imm; Rd_E forced 0.
  - Branch 1100011: Branch, SUB rs1-rs2; Rd_E forced 0.
  - JAL 1101111: Jump, RegWrite, ResultSrc=10, ADD PC+imm.
  - JALR 1100111: Jump, RegWrite, ResultSrc=10, ADD rs1+imm.
  - LUI 0110111: RegWrite, zero+imm.
  - AUIPC 0010111: RegWrite, PC+imm.
  - Any other opcode: all control 0, Illegal_E=1, Valid_E=1.
- A bubble in IF/ID (valid=0) produces Valid_E=0 with all control 0, even though NOP_INSTR decodes as a legal addi.

Test Plan:
- Reset: hold reset=0 for 2 edges with arbitrary inputs -> all ID/EX outputs 0; a subsequent read of x5 returns 0.
- Decode: addi x1,x0,-5 (0xFFB00093), PC_D=0x100 -> two edges later: PC_E=0x100, ImmExt_E=0xFFFFFFFFFFFFFFFB, RegWrite_E=1, ALUSrcB_E=1, ALUControl_E=0, Rd_E=1.
- Bypass: RegWrite_W=1, Rd_W=3, Result_W=0xDEAD in the same cycle that add x4,x3,x3 sits in IF/ID -> RD1_E=RD2_E=0xDEAD; a write to x0 leaves RD1_E=0.
- Stall and flush: StallD=1 plus FlushE=1 for one cycle -> IF/ID holds, Valid_E=0, RegWrite_E=0; the held instruction appears next cycle. StallD=1 with FlushD=1 -> bubble wins.
- Immediate types: beq with offset -8 -> ImmExt_E=0xFFFFFFFFFFFFFFF8, Branch_E=1, Rd_E=0. jal with offset 0x800 -> ImmExt_E=0x800, ResultSrc_E=10.
- Illegal and mid-operation reset: opcode 0x7F -> Illegal_E=1, all control 0. Reset asserted while a valid instruction sits in IF/ID -> next edge Valid_E=0.
